rx_packet_ctrl: RTL and testbench
=================================

// Module: rx_packet_ctrl
//
// PURPOSE
// Packet-level receive sequencer behind the preamble detector. It enables
// the detector while hunting. It slices the bit stream at mid-bit after a
// detection, then checks the 32-bit access address. It then frames the PDU
// header, payload and CRC as a byte stream with a valid/ready handshake.
// It sits between the matched-filter/preamble-detect datapath and the
// downstream CRC/dewhitening consumer.
//
// PARAMETERS
// SAMPLE_RATE   16            samples per bit; even, >=4
// ACCESS_ADDR   32'h8E89BED6  expected access address, compared LSB-first
// AA_TOL        0             max mismatching AA bits still accepted (0..4)
// MAX_LEN       37            largest legal PDU length byte
// CRC_BYTES     3             trailing bytes streamed after the payload
//
// PORTS
// clk              in   1  system clock
// resetn           in   1  synchronous active-low reset
// en               in   1  sample-rate enable; all state advances only when high
// data_bit         in   1  matched-filter bit decision, one per enabled cycle
// preamble_detected in  1  detector hit, valid on enabled cycles
// det_en           out  1  detector enable; high only in SEARCH
// byte_out         out  8  received byte, LSB = first bit on air
// byte_valid       out  1  byte_out holds an unconsumed byte
// byte_ready       in   1  consumer accepts byte_out when valid & ready
// pkt_start        out  1  1-cycle pulse: AA accepted, framing begins
// pkt_end          out  1  1-cycle pulse: last CRC byte loaded into byte_out
// pkt_err          out  2  with pkt_end or abort: 0 ok, 1 AA fail, 2 bad length, 3 overflow
// busy             out  1  high in any state except SEARCH
//
// BEHAVIOUR
// - Reset: synchronous, resetn=0 at a clk edge -> state SEARCH, counters 0.
//   All outputs 0 except det_en=1. Reset mid-packet drops the packet silently.
// - en=0: state, counters, shift register and byte_valid hold. Only the
//   byte_ready handshake (clearing byte_valid) still operates.
// - Bit slicer: D is the enabled cycle in which preamble_detected=1 in SEARCH.
//   data_bit is sampled on enabled cycles D+SAMPLE_RATE/2+k*SAMPLE_RATE,
//   for k=0,1,... Counting uses a phase counter that reloads with
//   SAMPLE_RATE-1 at each sample.
// - FSM states: SEARCH -> ACCESS_ADDR -> HEADER -> PAYLOAD -> SEARCH.
//   SEARCH:      preamble_detected -> ACCESS_ADDR; preload phase counter.
//   ACCESS_ADDR: shift 32 bits LSB-first. At the 32nd bit, compute
//                popcount(shift^ACCESS_ADDR). If <=AA_TOL: pulse pkt_start,
//                go to HEADER. Otherwise pulse pkt_end with pkt_err=1 and
//                go to SEARCH.
//   HEADER:      2 bytes; 2nd byte is LEN. LEN>MAX_LEN -> pkt_end,
//                pkt_err=2, SEARCH (both header bytes are still emitted).
//   PAYLOAD:     LEN bytes then CRC_BYTES bytes. The final byte pulses
//                pkt_end with pkt_err=0 in the cycle it loads. Next state SEARCH.
// - Byte emit: every 8th sampled bit in HEADER/PAYLOAD loads byte_out and
//   sets byte_valid in the same cycle. byte_valid clears on valid&ready.
//   If a new byte completes while byte_valid=1 and byte_ready=0: overflow.
//   Then byte_out is not overwritten, pkt_end pulses with pkt_err=3, and
//   the state goes to SEARCH.
// - Load and accept in the same cycle is legal; byte_valid stays 1 with the
//   new byte.
// - preamble_detected is ignored outside SEARCH. det_en=0 there. The
//   detector keeps its history while disabled.
// - LEN=0: 2 header + CRC_BYTES bytes. Total bytes = 2+LEN+CRC_BYTES.
//   The byte counter is 6 bits wide and must not wrap.
// - pkt_start, pkt_end: single enabled-cycle pulses. pkt_err is valid only
//   when pkt_end=1, else 0.
//
// TESTING
// - Reset: hold resetn=0 for 3 clks mid-PAYLOAD -> det_en=1, busy=0,
//   byte_valid=0, no pkt_end.
// - Good packet: preamble, AA 8E89BED6, hdr 0x02,0x03, payload 11 22 33,
//   CRC AA BB CC, ready=1 -> pkt_start then 8 bytes in order, pkt_end on CC.
//   pkt_err=0.
// - AA with 1 bit flipped, AA_TOL=0 -> pkt_end with pkt_err=1 at bit 32.
//   AA_TOL=1 -> packet accepted.
// - Length byte 0x30 (48>37) -> 2 header bytes out, then pkt_end with
//   pkt_err=2, back to SEARCH.
// - byte_ready held 0 after the first header byte -> overflow at byte 2.
//   byte_out keeps byte 1, pkt_err=3.
// - en toggling 1/0 every cycle during a good packet -> identical byte
//   sequence; bit timing counts enabled cycles only.

Source files
------------

// File: rtl/rx_packet_ctrl_if.sv
// Byte-stream handshake between the receive sequencer and the downstream consumer.
// The master drives bytes; the slave returns byte_ready.
interface rx_packet_ctrl_if;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_out, output byte_valid, input byte_ready);
    modport slave  (input byte_out, input byte_valid, output byte_ready);
endinterface

// File: rtl/rx_packet_ctrl.sv
// Packet-level receive sequencer: hunts for a preamble, slices bits at mid-bit,
// checks the access address and frames header/payload/CRC as a byte stream.
module rx_packet_ctrl #(
    parameter int          SAMPLE_RATE = 16,
    parameter logic [31:0] ACCESS_ADDR = 32'h8E89BED6,
    parameter int          AA_TOL      = 0,
    parameter int          MAX_LEN     = 37,
    parameter int          CRC_BYTES   = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               en,
    input  logic               data_bit,
    input  logic               preamble_detected,
    output logic               det_en,
    output logic               pkt_start,
    output logic               pkt_end,
    output logic [1:0]         pkt_err,
    output logic               busy,
    rx_packet_ctrl_if.master   bus
);

    localparam int PH_W = (SAMPLE_RATE > 2) ? $clog2(SAMPLE_RATE) : 1;
    localparam logic [PH_W-1:0] PH_LOAD = PH_W'(SAMPLE_RATE - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(SAMPLE_RATE / 2 - 1);

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_AA      = 2'd1,
        S_HEADER  = 2'd2,
        S_PAYLOAD = 2'd3
    } state_t;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

    state_t          state_r;
    logic [PH_W-1:0] phase_r;
    logic [31:0]     aa_sr_r;
    logic [4:0]      aa_cnt_r;
    logic [7:0]      byte_sr_r;
    logic [2:0]      bit_cnt_r;
    logic [5:0]      byte_cnt_r;
    logic [7:0]      len_r;
    logic [7:0]      byte_out_r;
    logic            byte_valid_r;
    logic            det_en_r;
    logic            busy_r;
    logic            pkt_start_r;
    logic            pkt_end_r;
    logic [1:0]      pkt_err_r;

    logic [31:0] aa_next_s;
    logic [7:0]  byte_next_s;
    logic        aa_ok_s;
    logic        overflow_s;
    logic        last_byte_s;

    // Bits arrive LSB-first, so each new bit enters at the top and the first bit ends at bit 0.
    assign aa_next_s   = {data_bit, aa_sr_r[31:1]};
    assign byte_next_s = {data_bit, byte_sr_r[7:1]};
    assign aa_ok_s     = (popcount32(aa_next_s ^ ACCESS_ADDR) <= 6'(AA_TOL));
    assign overflow_s  = byte_valid_r && !bus.byte_ready;
    assign last_byte_s = ({2'b00, byte_cnt_r} == (len_r + 8'(CRC_BYTES + 1)));

    // Sequencer FSM, bit slicer, byte framing and handshake, all with registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= S_SEARCH;
            phase_r      <= '0;
            aa_sr_r      <= 32'd0;
            aa_cnt_r     <= 5'd0;
            byte_sr_r    <= 8'd0;
            bit_cnt_r    <= 3'd0;
            byte_cnt_r   <= 6'd0;
            len_r        <= 8'd0;
            byte_out_r   <= 8'd0;
            byte_valid_r <= 1'b0;
            det_en_r     <= 1'b1;
            busy_r       <= 1'b0;
            pkt_start_r  <= 1'b0;
            pkt_end_r    <= 1'b0;
            pkt_err_r    <= 2'd0;
        end else begin
            pkt_start_r <= 1'b0;
            pkt_end_r   <= 1'b0;
            pkt_err_r   <= 2'd0;
            // The consumer handshake runs regardless of en; a load below overrides the clear.
            if (byte_valid_r && bus.byte_ready) begin
                byte_valid_r <= 1'b0;
            end
            if (en) begin
                if (state_r == S_SEARCH) begin
                    if (preamble_detected) begin
                        state_r  <= S_AA;
                        phase_r  <= PH_HALF;
                        aa_cnt_r <= 5'd0;
                        det_en_r <= 1'b0;
                        busy_r   <= 1'b1;
                    end
                end else if (phase_r != '0) begin
                    phase_r <= phase_r - 1'b1;
                end else begin
                    phase_r <= PH_LOAD;
                    case (state_r)
                        S_AA: begin
                            aa_sr_r  <= aa_next_s;
                            aa_cnt_r <= aa_cnt_r + 5'd1;
                            if (aa_cnt_r == 5'd31) begin
                                if (aa_ok_s) begin
                                    pkt_start_r <= 1'b1;
                                    state_r     <= S_HEADER;
                                    bit_cnt_r   <= 3'd0;
                                    byte_cnt_r  <= 6'd0;
                                end else begin
                                    pkt_end_r <= 1'b1;
                                    pkt_err_r <= 2'd1;
                                    state_r   <= S_SEARCH;
                                    det_en_r  <= 1'b1;
                                    busy_r    <= 1'b0;
                                end
                            end
                        end
                        S_HEADER, S_PAYLOAD: begin
                            byte_sr_r <= byte_next_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                if (overflow_s) begin
                                    pkt_end_r <= 1'b1;
                                    pkt_err_r <= 2'd3;
                                    state_r   <= S_SEARCH;
                                    det_en_r  <= 1'b1;
                                    busy_r    <= 1'b0;
                                end else begin
                                    byte_out_r   <= byte_next_s;
                                    byte_valid_r <= 1'b1;
                                    byte_cnt_r   <= byte_cnt_r + 6'd1;
                                    if (state_r == S_HEADER && byte_cnt_r == 6'd1) begin
                                        if (byte_next_s > 8'(MAX_LEN)) begin
                                            pkt_end_r <= 1'b1;
                                            pkt_err_r <= 2'd2;
                                            state_r   <= S_SEARCH;
                                            det_en_r  <= 1'b1;
                                            busy_r    <= 1'b0;
                                        end else begin
                                            len_r   <= byte_next_s;
                                            state_r <= S_PAYLOAD;
                                        end
                                    end else if (state_r == S_PAYLOAD && last_byte_s) begin
                                        pkt_end_r <= 1'b1;
                                        pkt_err_r <= 2'd0;
                                        state_r   <= S_SEARCH;
                                        det_en_r  <= 1'b1;
                                        busy_r    <= 1'b0;
                                    end
                                end
                            end
                        end
                        default: begin
                            state_r  <= S_SEARCH;
                            det_en_r <= 1'b1;
                            busy_r   <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign det_en         = det_en_r;
    assign busy           = busy_r;
    assign pkt_start      = pkt_start_r;
    assign pkt_end        = pkt_end_r;
    assign pkt_err        = pkt_err_r;
    assign bus.byte_out   = byte_out_r;
    assign bus.byte_valid = byte_valid_r;

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Scoreboard bench for rx_packet_ctrl: two instances differ only in AA_TOL (0 and 1).
// Data bits are valid only at the exact mid-bit sample cycle and random elsewhere.
module tb_rx_packet_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn, en, data_bit, preamble_detected, ready, toggle;
    logic det_en0, pkt_start0, pkt_end0, busy0;
    logic det_en1, pkt_start1, pkt_end1, busy1;
    logic [1:0] pkt_err0, pkt_err1;

    rx_packet_ctrl_if bus0();
    rx_packet_ctrl_if bus1();
    assign bus0.byte_ready = ready;
    assign bus1.byte_ready = ready;

    rx_packet_ctrl #(.AA_TOL(0)) dut0 (
        .clk(clk), .resetn(resetn), .en(en), .data_bit(data_bit),
        .preamble_detected(preamble_detected), .det_en(det_en0),
        .pkt_start(pkt_start0), .pkt_end(pkt_end0), .pkt_err(pkt_err0),
        .busy(busy0), .bus(bus0)
    );

    rx_packet_ctrl #(.AA_TOL(1)) dut1 (
        .clk(clk), .resetn(resetn), .en(en), .data_bit(data_bit),
        .preamble_detected(preamble_detected), .det_en(det_en1),
        .pkt_start(pkt_start1), .pkt_end(pkt_end1), .pkt_err(pkt_err1),
        .busy(busy1), .bus(bus1)
    );

    int n_checks = 0;
    int n_errs   = 0;
    int start0   = 0;
    int start_exp = 0;
    int start1, endok1, bytes1;
    logic [7:0] exp_q[$];
    logic [1:0] exp_err_q[$];
    logic [7:0] tx_q[$];
    logic       bits_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard side: consume bytes and packet-end events from dut0, tally dut1.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (bus0.byte_valid && ready) begin
                if (exp_q.size() == 0) chk("byte_unexpected", 32'd1, 32'd0);
                else chk("byte", {24'd0, bus0.byte_out}, {24'd0, exp_q.pop_front()});
            end
            if (pkt_start0) start0++;
            if (pkt_end0) begin
                if (exp_err_q.size() == 0) chk("pkt_end_unexpected", 32'd1, 32'd0);
                else chk("pkt_err", {30'd0, pkt_err0}, {30'd0, exp_err_q.pop_front()});
            end else if (pkt_err0 != 2'd0) begin
                chk("pkt_err_idle", {30'd0, pkt_err0}, 32'd0);
            end
            if (bus1.byte_valid && ready) bytes1++;
            if (pkt_start1) start1++;
            if (pkt_end1 && pkt_err1 == 2'd0) endok1++;
        end
    end

    task automatic cyc(input logic pd, input logic b);
        if (toggle) begin
            @(posedge clk); #1;
            en = 1'b0;
            data_bit = 1'($urandom);
            preamble_detected = 1'($urandom);
        end
        @(posedge clk); #1;
        en = 1'b1;
        preamble_detected = pd;
        data_bit = b;
    endtask

    task automatic build(input logic [31:0] aa);
        bits_q.delete();
        for (int i = 0; i < 32; i++) bits_q.push_back(aa[i]);
        foreach (tx_q[n]) begin
            for (int i = 0; i < 8; i++) bits_q.push_back(tx_q[n][i]);
        end
    endtask

    // Only the enabled cycle D+8+16k carries bit k; every other cycle is noise.
    task automatic send(input int nb);
        cyc(1'b1, 1'($urandom));
        for (int j = 1; j <= 16 * nb; j++) begin
            if (j % 16 == 8) cyc(1'b0, bits_q[(j - 8) / 16]);
            else cyc(1'b0, 1'($urandom));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom));
    endtask

    task automatic expect_bytes(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(tx_q[i]);
    endtask

    task automatic end_test(input string t);
        idle(24);
        chk({t, "_bytes_left"}, exp_q.size(), 32'd0);
        chk({t, "_ends_left"}, exp_err_q.size(), 32'd0);
        chk({t, "_starts"}, start0, start_exp);
        chk({t, "_det_en_idle"}, {31'd0, det_en0}, 32'd1);
        chk({t, "_busy_idle"}, {31'd0, busy0}, 32'd0);
    endtask

    initial begin
        resetn = 1'b0; en = 1'b0; data_bit = 1'b0; preamble_detected = 1'b0;
        ready = 1'b1; toggle = 1'b0;
        start1 = 0; endok1 = 0; bytes1 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_det_en", {31'd0, det_en0}, 32'd1);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_valid", {31'd0, bus0.byte_valid}, 32'd0);
        chk("rst_byte_out", {24'd0, bus0.byte_out}, 32'd0);
        chk("rst_start", {31'd0, pkt_start0}, 32'd0);
        chk("rst_end", {31'd0, pkt_end0}, 32'd0);
        chk("rst_err", {30'd0, pkt_err0}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        idle(5);

        // Good packet.
        tx_q = '{8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'hAA, 8'hBB, 8'hCC};
        build(32'h8E89BED6);
        expect_bytes(8); exp_err_q.push_back(2'd0); start_exp++;
        send(32 + 64);
        end_test("good");

        // One flipped AA bit: rejected by dut0, accepted by dut1.
        start1 = 0; endok1 = 0; bytes1 = 0;
        build(32'h8E89BED6 ^ 32'h0000_0020);
        exp_err_q.push_back(2'd1);
        send(32 + 64);
        end_test("aa_flip");
        chk("aa_tol1_start", start1, 32'd1);
        chk("aa_tol1_end_ok", endok1, 32'd1);
        chk("aa_tol1_bytes", bytes1, 32'd8);

        // Length above MAX_LEN: both header bytes out, then abort.
        tx_q = '{8'h7E, 8'h30};
        build(32'h8E89BED6);
        expect_bytes(2); exp_err_q.push_back(2'd2); start_exp++;
        send(32 + 16);
        end_test("bad_len");

        // LEN=0: header plus CRC bytes only.
        tx_q = '{8'h01, 8'h00, 8'hC1, 8'hC2, 8'hC3};
        build(32'h8E89BED6);
        expect_bytes(5); exp_err_q.push_back(2'd0); start_exp++;
        send(32 + 40);
        end_test("len0");

        // Overflow: first header byte never accepted.
        ready = 1'b0;
        tx_q = '{8'h5A, 8'h03};
        build(32'h8E89BED6);
        exp_err_q.push_back(2'd3); start_exp++;
        send(32 + 16);
        idle(4);
        @(negedge clk);
        chk("ovf_byte_kept", {24'd0, bus0.byte_out}, 32'h5A);
        chk("ovf_valid", {31'd0, bus0.byte_valid}, 32'd1);
        exp_q.push_back(8'h5A);
        @(posedge clk); #1;
        ready = 1'b1;
        end_test("overflow");

        // en toggling every cycle: same bytes, timing in enabled cycles.
        toggle = 1'b1;
        tx_q = '{8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'hAA, 8'hBB, 8'hCC};
        build(32'h8E89BED6);
        expect_bytes(8); exp_err_q.push_back(2'd0); start_exp++;
        send(32 + 64);
        end_test("en_toggle");
        toggle = 1'b0;

        // Reset mid-PAYLOAD drops the packet silently.
        tx_q = '{8'h02, 8'h05, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h01, 8'h02, 8'h03};
        build(32'h8E89BED6);
        expect_bytes(2); start_exp++;
        send(32 + 16 + 4);
        @(negedge clk);
        chk("mid_busy", {31'd0, busy0}, 32'd1);
        chk("mid_det_en", {31'd0, det_en0}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst2_det_en", {31'd0, det_en0}, 32'd1);
        chk("rst2_busy", {31'd0, busy0}, 32'd0);
        chk("rst2_valid", {31'd0, bus0.byte_valid}, 32'd0);
        chk("rst2_end", {31'd0, pkt_end0}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        end_test("mid_reset");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
